// File: rtl/mac_pipe_pkg.sv
// Shared definitions for the pipelined multiply-accumulate block:
// operation encodings and signed range helpers for the accumulator width.
package mac_pipe_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MAC    = 2'd1,
        OP_MSU    = 2'd2,
        OP_CLRMUL = 2'd3
    } op_e;

    // Wide enough for any legal accumulator width; callers truncate to their width.
    function automatic logic [127:0] acc_max(input int w);
        return (128'd1 << (w - 1)) - 128'd1;
    endfunction

    function automatic logic [127:0] acc_min(input int w);
        return ~acc_max(w);
    endfunction

endpackage

// File: rtl/mac_pipe_mult.sv
// Operand extension, exact signed multiply and a valid-tagged register chain
// that carries the operation alongside each product.
module mac_pipe_mult
    import mac_pipe_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 2 * WIDTH + 8,
    parameter int STAGES    = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        EN,
    input  logic                        VLD,
    input  logic [WIDTH-1:0]            A,
    input  logic [WIDTH-1:0]            B,
    input  logic                        A_SIGNED,
    input  logic                        B_SIGNED,
    input  logic [1:0]                  OP,
    output logic                        PROD_VLD,
    output logic signed [ACC_WIDTH-1:0] PROD,
    output op_e                         PROD_OP
);

    localparam int MW = 2 * WIDTH + 2;

    logic signed [WIDTH:0]          a_ext;
    logic signed [WIDTH:0]          b_ext;
    logic signed [MW-1:0]           mul_c;
    logic signed [ACC_WIDTH-1:0]    prod_c;

    logic                           vld_p  [STAGES];
    logic signed [ACC_WIDTH-1:0]    prod_p [STAGES];
    op_e                            op_p   [STAGES];

    // One extra bit per operand makes every signedness combination an exact signed product.
    assign a_ext  = {A_SIGNED & A[WIDTH-1], A};
    assign b_ext  = {B_SIGNED & B[WIDTH-1], B};
    assign mul_c  = MW'(a_ext) * MW'(b_ext);
    assign prod_c = ACC_WIDTH'(mul_c);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < STAGES; i++) vld_p[i] <= 1'b0;
        end else if (EN) begin
            vld_p[0] <= VLD;
            for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (EN) begin
            prod_p[0] <= prod_c;
            op_p[0]   <= op_e'(OP);
            for (int i = 1; i < STAGES; i++) begin
                prod_p[i] <= prod_p[i-1];
                op_p[i]   <= op_p[i-1];
            end
        end
    end

    assign PROD_VLD = vld_p[STAGES-1];
    assign PROD     = prod_p[STAGES-1];
    assign PROD_OP  = op_p[STAGES-1];

endmodule

// File: rtl/mac_pipe.sv
// Pipelined multiply-accumulate with ready/valid handshake; accumulation,
// overflow detection and optional saturation happen in the output stage.
module mac_pipe
    import mac_pipe_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 2 * WIDTH + 8,
    parameter int STAGES    = 2,
    parameter int SATURATE  = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 A_SIGNED,
    input  logic                 B_SIGNED,
    input  logic [1:0]           OP,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [ACC_WIDTH-1:0] O,
    output logic                 OVF
);

    localparam logic signed [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'(acc_max(ACC_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] SMIN = ACC_WIDTH'(acc_min(ACC_WIDTH));

    logic                        stall;
    logic                        vld_pl;
    logic signed [ACC_WIDTH-1:0] prod_pl;
    op_e                         op_pl;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH:0]   sum_c;
    logic                        ovf_c;
    logic signed [ACC_WIDTH-1:0] res_c;

    function automatic logic signed [ACC_WIDTH:0] add_sub(
        input logic signed [ACC_WIDTH-1:0] x,
        input logic signed [ACC_WIDTH-1:0] y,
        input logic                        sub
    );
        logic signed [ACC_WIDTH:0] xe;
        logic signed [ACC_WIDTH:0] ye;
        xe = {x[ACC_WIDTH-1], x};
        ye = {y[ACC_WIDTH-1], y};
        return sub ? (xe - ye) : (xe + ye);
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sat_wrap(
        input logic signed [ACC_WIDTH:0] s,
        input logic                      of
    );
        if (of && SATURATE != 0) return s[ACC_WIDTH] ? SMIN : SMAX;
        return s[ACC_WIDTH-1:0];
    endfunction

    assign stall    = OUT_VALID && !OUT_READY;
    assign IN_READY = !stall;

    mac_pipe_mult #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .STAGES    (STAGES)
    ) u_mult (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (!stall),
        .VLD      (IN_VALID),
        .A        (A),
        .B        (B),
        .A_SIGNED (A_SIGNED),
        .B_SIGNED (B_SIGNED),
        .OP       (OP),
        .PROD_VLD (vld_pl),
        .PROD     (prod_pl),
        .PROD_OP  (op_pl)
    );

    assign sum_c = add_sub(acc, prod_pl, op_pl == OP_MSU);
    assign ovf_c = sum_c[ACC_WIDTH] ^ sum_c[ACC_WIDTH-1];
    assign res_c = sat_wrap(sum_c, ovf_c);

    // Output stage: accumulator and O register together
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            acc       <= '0;
            O         <= '0;
            OVF       <= 1'b0;
        end else if (!stall) begin
            OUT_VALID <= vld_pl;
            if (vld_pl) begin
                unique case (op_pl)
                    OP_MUL: O <= prod_pl;
                    OP_CLRMUL: begin
                        acc <= prod_pl;
                        O   <= prod_pl;
                        OVF <= 1'b0;
                    end
                    default: begin
                        acc <= res_c;
                        O   <= res_c;
                        OVF <= OVF | ovf_c;
                    end
                endcase
            end
        end
    end

endmodule
